up_mmio_bank: RTL and testbench

Parametrised memory-mapped I/O bank for the up_core family. It replaces the fixed four-in/four-out `mem_map_*` ports with CHANNELS configurable channels of DATA_W bits. Each input has valid-edge capture, pending and overrun flags and a per-channel interrupt enable, and the block drives an active-low interrupt request. It sits between the core's data-memory bus and the pins or peripherals.

---
 rtl/up_mmio_pkg.sv | 28 ++
 rtl/up_mmio_in_chan.sv | 48 ++++
 rtl/up_mmio_bank.sv | 105 ++++++++++
 tb/tb_up_mmio_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/up_mmio_pkg.sv
// Shared constants and register-offset helpers for the up_core MMIO bank.
package up_mmio_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;

  function automatic int unsigned off_out_rb(input int unsigned c);
    return c;
  endfunction

  function automatic int unsigned off_status(input int unsigned c);
    return 2 * c;
  endfunction

  function automatic int unsigned off_ie(input int unsigned c);
    return 2 * c + 1;
  endfunction

  function automatic int unsigned off_ovr(input int unsigned c);
    return 2 * c + 2;
  endfunction

  // Every channel needs its own bit in STATUS, IE and OVERRUN.
  function automatic bit chan_ok(input int unsigned c, input int unsigned w);
    return (c >= 1) && (c <= w);
  endfunction

endpackage

// File: rtl/up_mmio_in_chan.sv
// One input channel: valid rising-edge capture with pending and overrun flags.
module up_mmio_in_chan
  import up_mmio_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              clr_pend,
  input  logic              clr_ovr,
  output logic [DATA_W-1:0] data_q,
  output logic              pending,
  output logic              overrun
);

  logic valid_q;
  logic rise;
  logic ovr_set;

  assign rise    = valid & ~valid_q;
  // A capture on an unread, uncleared value is the only overrun source.
  assign ovr_set = rise & pending & ~clr_pend;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid_q <= valid;
      if (rise) begin
        data_q  <= data;
        pending <= 1'b1;
      end else if (clr_pend) begin
        pending <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/up_mmio_bank.sv
// Parametrised MMIO bank: address decode, output registers, IE, read mux and nInt.
module up_mmio_bank
  import up_mmio_pkg::*;
#(
  parameter int unsigned          DATA_W    = DEF_DATA_W,
  parameter int unsigned          CHANNELS  = 4,
  parameter int unsigned          ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'('hF0)
) (
  input  logic                            clk,
  input  logic                            nRst,
  input  logic [ADDR_W-1:0]               bus_addr,
  input  logic                            bus_wr,
  input  logic [DATA_W-1:0]               bus_wdata,
  input  logic                            bus_rd,
  output logic [DATA_W-1:0]               bus_rdata,
  input  logic [CHANNELS*(DATA_W+1)-1:0]  map_in,
  output logic [CHANNELS*DATA_W-1:0]      map_out,
  output logic                            nInt
);

  if (!chan_ok(CHANNELS, DATA_W)) begin : g_bad_cfg
    $error("up_mmio_bank: CHANNELS must be in 1..DATA_W");
  end

  localparam logic [ADDR_W-1:0] OFF_RB = ADDR_W'(off_out_rb(CHANNELS));
  localparam logic [ADDR_W-1:0] OFF_ST = ADDR_W'(off_status(CHANNELS));
  localparam logic [ADDR_W-1:0] OFF_IE = ADDR_W'(off_ie(CHANNELS));
  localparam logic [ADDR_W-1:0] OFF_OV = ADDR_W'(off_ovr(CHANNELS));

  logic [ADDR_W-1:0]   off;
  logic                in_win;
  logic                wr_c;
  logic                rd_c;
  logic [CHANNELS-1:0] clr_pend;
  logic [CHANNELS-1:0] clr_ovr;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] ovr;
  logic [CHANNELS-1:0] ie;
  logic [DATA_W-1:0]   in_data [CHANNELS];
  logic [DATA_W-1:0]   out_q   [CHANNELS];
  logic [DATA_W-1:0]   rdata_c;

  // The window never wraps, so one lower-bound compare rejects low addresses.
  assign off    = bus_addr - BASE_ADDR;
  assign in_win = (bus_addr >= BASE_ADDR);
  assign wr_c   = bus_wr & in_win;
  assign rd_c   = bus_rd & ~bus_wr & in_win;

  always_comb begin
    clr_pend = '0;
    clr_ovr  = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      clr_pend[c] = (rd_c && (off == ADDR_W'(c))) ||
                    (wr_c && (off == OFF_ST) && bus_wdata[c]);
      clr_ovr[c]  = wr_c && (off == OFF_OV) && bus_wdata[c];
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    up_mmio_in_chan #(.DATA_W(DATA_W)) u_in (
      .clk      (clk),
      .nRst     (nRst),
      .valid    (map_in[g*(DATA_W+1)+DATA_W]),
      .data     (map_in[g*(DATA_W+1) +: DATA_W]),
      .clr_pend (clr_pend[g]),
      .clr_ovr  (clr_ovr[g]),
      .data_q   (in_data[g]),
      .pending  (pend[g]),
      .overrun  (ovr[g])
    );
    assign map_out[g*DATA_W +: DATA_W] = out_q[g];
  end

  // Read mux; unmatched offsets and read-with-write fall through to zero.
  always_comb begin
    rdata_c = '0;
    if (rd_c) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (off == ADDR_W'(c))          rdata_c = in_data[c];
        if (off == OFF_RB + ADDR_W'(c)) rdata_c = out_q[c];
      end
      if (off == OFF_ST) rdata_c = DATA_W'(pend);
      if (off == OFF_IE) rdata_c = DATA_W'(ie);
      if (off == OFF_OV) rdata_c = DATA_W'(ovr);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int c = 0; c < int'(CHANNELS); c++) out_q[c] <= '0;
      ie        <= '0;
      bus_rdata <= '0;
      nInt      <= 1'b1;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (wr_c && (off == ADDR_W'(c))) out_q[c] <= bus_wdata;
      end
      if (wr_c && (off == OFF_IE)) ie <= bus_wdata[CHANNELS-1:0];
      if (bus_rd) bus_rdata <= rdata_c;
      nInt <= ~|(pend & ie);
    end
  end

endmodule

// File: tb/tb_up_mmio_bank.sv
// Directed bench for up_mmio_bank: 4-channel default instance plus an 8-channel instance at 8'hE0.
module tb_up_mmio_bank;

  logic        clk = 1'b0;
  logic        nRst;

  logic [7:0]  a_addr, a_wdata, a_rdata;
  logic        a_wr, a_rd, a_nint;
  logic [35:0] a_map_in;
  logic [31:0] a_map_out;

  logic [7:0]  b_addr, b_wdata, b_rdata;
  logic        b_wr, b_rd, b_nint;
  logic [71:0] b_map_in;
  logic [63:0] b_map_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd;

  always #5 clk = ~clk;

  up_mmio_bank u_dut_a (
    .clk(clk), .nRst(nRst), .bus_addr(a_addr), .bus_wr(a_wr), .bus_wdata(a_wdata),
    .bus_rd(a_rd), .bus_rdata(a_rdata), .map_in(a_map_in), .map_out(a_map_out), .nInt(a_nint)
  );

  up_mmio_bank #(.DATA_W(8), .CHANNELS(8), .ADDR_W(8), .BASE_ADDR(8'hE0)) u_dut_b (
    .clk(clk), .nRst(nRst), .bus_addr(b_addr), .bus_wr(b_wr), .bus_wdata(b_wdata),
    .bus_rd(b_rd), .bus_rdata(b_rdata), .map_in(b_map_in), .map_out(b_map_out), .nInt(b_nint)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input bit b, input logic [7:0] addr, input logic [7:0] d);
    if (b) begin b_addr = addr; b_wdata = d; b_wr = 1'b1; end
    else   begin a_addr = addr; a_wdata = d; a_wr = 1'b1; end
    tick();
    a_wr = 1'b0;
    b_wr = 1'b0;
  endtask

  task automatic bus_read(input bit b, input logic [7:0] addr, output logic [7:0] d);
    if (b) begin b_addr = addr; b_rd = 1'b1; end
    else   begin a_addr = addr; a_rd = 1'b1; end
    tick();
    a_rd = 1'b0;
    b_rd = 1'b0;
    d = b ? b_rdata : a_rdata;
  endtask

  initial begin
    nRst = 1'b0;
    a_addr = '0; a_wdata = '0; a_wr = 1'b0; a_rd = 1'b0; a_map_in = '0;
    b_addr = '0; b_wdata = '0; b_wr = 1'b0; b_rd = 1'b0; b_map_in = '0;
    a_map_in[0*9 +: 9] = {1'b1, 8'h5A};

    // Reset with valid[0] held high
    tick(); tick();
    chk("rst_map_out", 64'(a_map_out), 64'h0);
    chk("rst_rdata", 64'(a_rdata), 64'h0);
    chk("rst_nint", 64'(a_nint), 64'h1);
    nRst = 1'b1;
    tick();
    chk("post_rst_nint_ie0", 64'(a_nint), 64'h1);
    bus_read(0, 8'hF8, rd); chk("post_rst_status", 64'(rd), 64'h01);
    bus_read(0, 8'hF0, rd); chk("post_rst_in0", 64'(rd), 64'h5A);
    bus_read(0, 8'hF9, rd); chk("post_rst_ie", 64'(rd), 64'h00);
    a_map_in[0*9 +: 9] = {1'b0, 8'h5A};

    // Interrupt on channel 1
    bus_write(0, 8'hF9, 8'h02);
    a_map_in[1*9 +: 9] = {1'b1, 8'hC3};
    tick();
    chk("irq_edge_n", 64'(a_nint), 64'h1);
    a_map_in[1*9 +: 9] = {1'b0, 8'hC3};
    tick();
    chk("irq_edge_n1", 64'(a_nint), 64'h0);
    bus_read(0, 8'hF1, rd); chk("irq_in1", 64'(rd), 64'hC3);
    chk("irq_hold_after_read", 64'(a_nint), 64'h0);
    tick();
    chk("irq_release", 64'(a_nint), 64'h1);

    // Overrun on channel 2
    a_map_in[2*9 +: 9] = {1'b1, 8'h11}; tick();
    a_map_in[2*9 +: 9] = {1'b0, 8'h11}; tick();
    a_map_in[2*9 +: 9] = {1'b1, 8'h22}; tick();
    a_map_in[2*9 +: 9] = {1'b0, 8'h22}; tick();
    bus_read(0, 8'hFA, rd); chk("ovr_set", 64'(rd), 64'h04);
    bus_read(0, 8'hF2, rd); chk("ovr_in2", 64'(rd), 64'h22);
    bus_write(0, 8'hFA, 8'h04);
    bus_read(0, 8'hFA, rd); chk("ovr_w1c", 64'(rd), 64'h00);
    bus_read(0, 8'hF8, rd); chk("status_clear", 64'(rd), 64'h00);

    // Outputs, readback and unused / out-of-window addresses
    bus_write(0, 8'hF3, 8'hA5);
    chk("out3", 64'(a_map_out), 64'hA500_0000);
    bus_read(0, 8'hF7, rd); chk("out3_rb", 64'(rd), 64'hA5);
    bus_write(0, 8'hFC, 8'hFF);
    chk("unused_wr", 64'(a_map_out), 64'hA500_0000);
    bus_read(0, 8'hFC, rd); chk("unused_rd", 64'(rd), 64'h00);
    bus_read(0, 8'hEF, rd); chk("below_base_rd", 64'(rd), 64'h00);

    // Simultaneous read and write: write wins, no read side effect
    a_map_in[0*9 +: 9] = {1'b1, 8'h77}; tick();
    a_map_in[0*9 +: 9] = {1'b0, 8'h77}; tick();
    bus_read(0, 8'hF7, rd); chk("pre_rdwr_rb", 64'(rd), 64'hA5);
    a_addr = 8'hF0; a_wdata = 8'h3C; a_wr = 1'b1; a_rd = 1'b1;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("rdwr_rdata", 64'(a_rdata), 64'h00);
    chk("rdwr_out0", 64'(a_map_out), 64'hA500_003C);
    bus_read(0, 8'hF8, rd); chk("rdwr_pend_kept", 64'(rd), 64'h01);
    bus_read(0, 8'hF0, rd); chk("rdwr_in0", 64'(rd), 64'h77);

    // Capture in the same cycle as a data read: capture wins
    a_map_in[0*9 +: 9] = {1'b1, 8'h99};
    a_addr = 8'hF0; a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    a_map_in[0*9 +: 9] = {1'b0, 8'h99};
    chk("race_old_data", 64'(a_rdata), 64'h77);
    bus_read(0, 8'hF8, rd); chk("race_pend", 64'(rd), 64'h01);
    bus_read(0, 8'hFA, rd); chk("race_no_ovr", 64'(rd), 64'h00);

    // Overrun set wins over W1C in the same cycle
    a_map_in[0*9 +: 9] = {1'b1, 8'hAA};
    bus_write(0, 8'hFA, 8'h01);
    a_map_in[0*9 +: 9] = {1'b0, 8'hAA};
    bus_read(0, 8'hFA, rd); chk("ovr_set_wins", 64'(rd), 64'h01);
    bus_read(0, 8'hF0, rd); chk("ovr_in0", 64'(rd), 64'hAA);
    bus_read(0, 8'hF8, rd); chk("ovr_pend_clr", 64'(rd), 64'h00);
    chk("nint_masked", 64'(a_nint), 64'h1);

    // Eight-channel instance at 8'hE0, channel 7
    bus_write(1, 8'hF1, 8'h80);
    b_map_in[7*9 +: 9] = {1'b1, 8'h5C};
    tick();
    chk("b_irq_edge_n", 64'(b_nint), 64'h1);
    b_map_in[7*9 +: 9] = {1'b0, 8'h5C};
    tick();
    chk("b_irq_edge_n1", 64'(b_nint), 64'h0);
    bus_read(1, 8'hF0, rd); chk("b_status", 64'(rd), 64'h80);
    bus_read(1, 8'hE7, rd); chk("b_in7", 64'(rd), 64'h5C);
    chk("b_irq_hold", 64'(b_nint), 64'h0);
    tick();
    chk("b_irq_release", 64'(b_nint), 64'h1);
    bus_read(1, 8'hF2, rd); chk("b_ovr", 64'(rd), 64'h00);
    bus_write(1, 8'hE6, 8'h6B);
    chk("b_out6", 64'(b_map_out), 64'h006B_0000_0000_0000);
    bus_read(1, 8'hEE, rd); chk("b_out6_rb", 64'(rd), 64'h6B);

    // Asynchronous reset mid-operation
    a_map_in[3*9 +: 9] = {1'b1, 8'h42};
    tick();
    a_map_in[3*9 +: 9] = {1'b0, 8'h42};
    #2 nRst = 1'b0;
    #1;
    chk("async_map_out", 64'(a_map_out), 64'h0);
    chk("async_rdata", 64'(a_rdata), 64'h0);
    chk("async_b_map_out", 64'(b_map_out), 64'h0);
    tick();
    nRst = 1'b1;
    tick();
    bus_read(0, 8'hF8, rd); chk("async_status", 64'(rd), 64'h00);
    bus_read(0, 8'hF3, rd); chk("async_in3", 64'(rd), 64'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
